// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Widens an IN_W-bit field to OUT_W bits and registers the result in one
//   elastic pipeline stage. Five modes are supported: sign-extend, zero-extend,
//   upper-place (LUI style), byte sign-extend and byte zero-extend. Any other
//   mode produces a zero result with out_err set.
//
//   The stage holds two entries. MAIN drives out_*. SKID catches one item
//   that arrives while MAIN is stalled. Because of this, in_ready can be a
//   plain register with no combinational path from out_ready.
//
// Handshake: a transfer happens on a rising Clk edge where valid and ready
//   are both high on that side. A producer holds in_valid/in_data/in_mode
//   until it sees in_ready. out_data/out_err are held stable while
//   out_valid=1 and out_ready=0.
//
// Ports
//   Clk        in   1      rising-edge clock
//   Reset      in   1      synchronous active-high reset (highest priority)
//   Flush      in   1      synchronous flush; drops MAIN, SKID and any same-cycle accept
//   in_valid   in   1      producer holds a valid item
//   in_ready   out  1      stage can accept an item this cycle (registered)
//   in_data    in   IN_W   field to extend
//   in_mode    in   3      000 SEXT, 001 ZEXT, 010 UPPER, 011 SEXT_B, 100 ZEXT_B
//   out_valid  out  1      out_data/out_err hold a valid item
//   out_ready  in   1      consumer accepts the item this cycle
//   out_data   out  OUT_W  extended result
//   out_err    out  1      item was issued with an illegal mode
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam logic [2:0] MODE_SEXT   = 3'b000;
  localparam logic [2:0] MODE_ZEXT   = 3'b001;
  localparam logic [2:0] MODE_UPPER  = 3'b010;
  localparam logic [2:0] MODE_SEXT_B = 3'b011;
  localparam logic [2:0] MODE_ZEXT_B = 3'b100;

  localparam int UP_SHIFT = OUT_W - IN_W;

  // Combinational extension of the incoming field.
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      // Sized casts of signed operands sign-extend, which also covers IN_W == OUT_W.
      MODE_SEXT:   ext_data = OUT_W'($signed(in_data));
      MODE_ZEXT:   ext_data = OUT_W'(in_data);
      MODE_UPPER:  ext_data = OUT_W'(in_data) << UP_SHIFT;
      MODE_SEXT_B: ext_data = OUT_W'($signed(in_data[7:0]));
      MODE_ZEXT_B: ext_data = OUT_W'(in_data[7:0]);
      default:     ext_err  = 1'b1;
    endcase
  end

  // Storage: MAIN feeds the outputs, SKID absorbs one item while MAIN is stalled.
  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic             main_err_q,   main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic             skid_err_q,   skid_err_d;
  logic             in_ready_q,   in_ready_d;

  logic accept;
  logic emit;

  assign accept = in_valid & in_ready_q;
  assign emit   = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;

    if (Flush) begin
      // Data registers keep stale values; only the valid bits and the error flag clear.
      main_valid_d = 1'b0;
      main_err_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || emit) begin
      // MAIN is free this edge. SKID, when occupied, is older than anything
      // arriving now (and in_ready is low then, so nothing can arrive).
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = ext_data;
        main_err_d   = ext_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // MAIN stalled: park the new item in SKID.
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_err_d   = ext_err;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe. Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge. Each accepted item pushes its
// hand-computed {err, data} into exp_q; the monitor pops on every emit.
module tb_imm_extend_pipe;

  localparam int W = 33;

  logic        Clk;
  logic        Reset;
  logic        Flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  // Narrow instance (IN_W=12, OUT_W=16)
  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [11:0] s_in_data;
  logic [2:0]  s_in_mode;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_out_data;
  logic        s_out_err;

  logic [W-1:0] exp_q[$];
  int           emit_cyc[$];
  int           cyc;
  int           total;
  int           bad;

  imm_extend_pipe u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(16)) u_small (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_mode   (s_in_mode),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_err   (s_out_err)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor / scoreboard
  initial cyc = 0;
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (!Reset && out_valid && out_ready) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL emit_unexpected: got err=%0b data=%h, required no item", out_err, out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({out_err, out_data} !== e) begin
          bad = bad + 1;
          $display("FAIL emit_data: got err=%0b data=%h, required err=%0b data=%h",
                   out_err, out_data, e[32], e[31:0]);
        end
      end
      emit_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Driver: called at posedge+1, returns at posedge+1 with in_valid low.
  task automatic send(input logic [15:0] d, input logic [2:0] m, input logic [W-1:0] e);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge Clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge Clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge Clk); #1;
      waited++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    Reset       = 1'b1;
    Flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_mode     = '0;
    out_ready   = 1'b0;
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_in_mode   = '0;
    s_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // SEXT, then the other legal modes streamed back to back
    out_ready = 1'b1;
    send(16'h8001, 3'b000, {1'b0, 32'hFFFF8001});
    send(16'h80F0, 3'b001, {1'b0, 32'h000080F0});
    send(16'h80F0, 3'b010, {1'b0, 32'h80F00000});
    send(16'h80F0, 3'b011, {1'b0, 32'hFFFFFFF0});
    send(16'h80F0, 3'b100, {1'b0, 32'h000000F0});
    send(16'h0F7F, 3'b011, {1'b0, 32'h0000007F});
    wait_drain("drain_modes");

    // Illegal modes, then a legal item clears the error
    send(16'h1234, 3'b110, {1'b1, 32'h00000000});
    send(16'h7FFF, 3'b000, {1'b0, 32'h00007FFF});
    send(16'hFFFF, 3'b111, {1'b1, 32'h00000000});
    send(16'hABCD, 3'b101, {1'b1, 32'h00000000});
    send(16'hFFFF, 3'b001, {1'b0, 32'h0000FFFF});
    wait_drain("drain_illegal");

    // Backpressure: A in MAIN, B in SKID, C held off
    out_ready = 1'b0;
    send(16'h0005, 3'b000, {1'b0, 32'h00000005});
    send(16'hFFFF, 3'b001, {1'b0, 32'h0000FFFF});
    in_valid = 1'b1;
    in_data  = 16'h0001;
    in_mode  = 3'b010;
    @(negedge Clk);
    check("bp_in_ready",  64'(in_ready),  64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_out_data",  64'(out_data),  64'h00000005);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("bp_hold_data",  64'(out_data), 64'h00000005);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    @(posedge Clk); #1;
    out_ready = 1'b1;
    send(16'h0001, 3'b010, {1'b0, 32'h00010000});
    wait_drain("drain_bp");
    if (emit_cyc.size() >= 3) begin
      int n;
      n = emit_cyc.size();
      check("bp_gap_ab", 64'(emit_cyc[n-2] - emit_cyc[n-3]), 64'd1);
      check("bp_gap_bc", 64'(emit_cyc[n-1] - emit_cyc[n-2]), 64'd1);
    end else begin
      check("bp_emit_count", 64'(emit_cyc.size()), 64'd3);
    end

    // Flush with two buffered items and a same-cycle valid input
    out_ready = 1'b0;
    send(16'h1111, 3'b001, {1'b0, 32'h00001111});
    send(16'h2222, 3'b001, {1'b0, 32'h00002222});
    Flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3333;
    in_mode  = 3'b001;
    exp_q.delete();
    @(posedge Clk); #1;
    Flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge Clk);
    check("flush2_out_valid", 64'(out_valid), 64'd0);
    check("flush2_in_ready",  64'(in_ready),  64'd1);
    check("flush2_out_err",   64'(out_err),   64'd0);
    @(posedge Clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;

    // Flush with one item in MAIN while a new item is being accepted
    out_ready = 1'b0;
    send(16'h1234, 3'b111, {1'b1, 32'h00000000});
    Flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h4444;
    in_mode  = 3'b000;
    exp_q.delete();
    @(posedge Clk); #1;
    Flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge Clk);
    check("flush1_out_valid", 64'(out_valid), 64'd0);
    check("flush1_out_err",   64'(out_err),   64'd0);
    @(posedge Clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;

    // Mid-stream reset with two buffered items
    out_ready = 1'b0;
    send(16'h5555, 3'b000, {1'b0, 32'h00005555});
    send(16'h6666, 3'b000, {1'b0, 32'h00006666});
    Reset = 1'b1;
    exp_q.delete();
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    check("mrst_out_data",  64'(out_data),  64'd0);
    @(posedge Clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;

    // Stage still works after flush/reset
    send(16'h00FF, 3'b011, {1'b0, 32'hFFFFFFFF});
    wait_drain("drain_post");

    // Narrow instance: SEXT 12'h800, UPPER 12'hABC
    s_in_valid = 1'b1;
    s_in_data  = 12'h800;
    s_in_mode  = 3'b000;
    @(posedge Clk); #1;
    s_in_data  = 12'hABC;
    s_in_mode  = 3'b010;
    @(negedge Clk);
    check("small_sext_valid", 64'(s_out_valid), 64'd1);
    check("small_sext_data",  64'(s_out_data),  64'hF800);
    @(posedge Clk); #1;
    s_in_valid = 1'b0;
    @(negedge Clk);
    check("small_upper_valid", 64'(s_out_valid), 64'd1);
    check("small_upper_data",  64'(s_out_data),  64'hABC0);
    check("small_upper_err",   64'(s_out_err),   64'd0);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("small_idle_valid", 64'(s_out_valid), 64'd0);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
